// File: rtl/mac_acc.sv
// rtl/mac_acc.sv - framed multiply-accumulate: sums LEN signed products, scales and fits to WO bits
// Optional ACC_SAT_EN: saturate the fitted result instead of wrapping.
module mac_acc #(
  parameter int WP    = 32,
  parameter int LEN   = 64,
  parameter int WACC  = WP + $clog2(LEN),
  parameter int SHIFT = 0,
  parameter int WO    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [WP-1:0]        p_in,
  input  logic                 flush,
  output logic                 valid_out,
  output logic [WO-1:0]        acc_out,
  output logic                 ovf_out,
  output logic                 busy
);

  localparam int CW = $clog2(LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

  logic [CW-1:0]          cnt;
  logic signed [WACC-1:0] acc;
  logic signed [WACC-1:0] ext;
  logic signed [WACC-1:0] base;
  logic signed [WACC-1:0] sum;
  logic signed [WACC-1:0] scaled;
  logic [WACC-WO:0]       top;
  logic                   ovf;
  logic [WO-1:0]          fit;
  logic                   last;

  // A fresh frame (idle or flushed) starts from zero rather than the stale accumulator.
  always_comb begin
    ext    = {{(WACC-WP){p_in[WP-1]}}, p_in};
    base   = (cnt == '0 || flush) ? '0 : acc;
    sum    = base + ext;
    scaled = sum >>> SHIFT;
    top    = scaled[WACC-1:WO-1];
    ovf    = (|top) & ~(&top);
`ifdef ACC_SAT_EN
    if (ovf)
      fit = scaled[WACC-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
    else
      fit = scaled[WO-1:0];
`else
    fit = scaled[WO-1:0];
`endif
    last = valid_in && !flush && (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      valid_out <= 1'b0;
      acc_out   <= '0;
      ovf_out   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (valid_in) begin
        acc <= sum;
        if (last) begin
          cnt       <= '0;
          busy      <= 1'b0;
          valid_out <= 1'b1;
          acc_out   <= fit;
          ovf_out   <= ovf;
        end else begin
          cnt  <= flush ? CW'(1) : cnt + CW'(1);
          busy <= 1'b1;
        end
      end else if (flush) begin
        cnt  <= '0;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_acc.sv
// tb/tb_mac_acc.sv - scoreboard bench for mac_acc (LEN=4); expectations follow ACC_SAT_EN
module tb_mac_acc;

`ifdef ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic signed [31:0] acc;
    logic               ovf;
    int                 cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        v1 = 0, f1 = 0;
  logic [31:0] p1 = '0;
  logic        vo1, ovf1, busy1;
  logic [31:0] acc1;

  logic        v2 = 0, f2 = 0;
  logic [31:0] p2 = '0;
  logic        vo2, ovf2, busy2;
  logic [15:0] acc2;

  exp_t q1[$];
  exp_t q2[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_acc #(.WP(32), .LEN(4), .SHIFT(0), .WO(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid_in(v1), .p_in(p1), .flush(f1),
    .valid_out(vo1), .acc_out(acc1), .ovf_out(ovf1), .busy(busy1)
  );

  mac_acc #(.WP(32), .LEN(4), .SHIFT(2), .WO(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid_in(v2), .p_in(p2), .flush(f2),
    .valid_out(vo2), .acc_out(acc2), .ovf_out(ovf2), .busy(busy2)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one sample for a single cycle; a 'last' sample registers the expected pulse.
  task automatic send(input int d, input logic signed [31:0] p, input bit fl,
                      input bit last, input logic signed [31:0] ea, input bit eo);
    exp_t e;
    @(negedge clk);
    if (d == 1) begin v1 = 1'b1; p1 = p; f1 = fl; end
    else        begin v2 = 1'b1; p2 = p; f2 = fl; end
    if (last) begin
      e.acc = ea; e.ovf = eo; e.cyc = cyc + 1;
      if (d == 1) q1.push_back(e); else q2.push_back(e);
    end
    @(posedge clk);
    #1;
    v1 = 1'b0; f1 = 1'b0; v2 = 1'b0; f2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int d, input logic signed [31:0] a, input logic signed [31:0] b,
                       input logic signed [31:0] c, input logic signed [31:0] x,
                       input logic signed [31:0] ea, input bit eo);
    send(d, a, 0, 0, 0, 0);
    send(d, b, 0, 0, 0, 0);
    send(d, c, 0, 0, 0, 0);
    send(d, x, 0, 1, ea, eo);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && vo1) begin
      n_chk++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL dut1_stray_pulse: got acc=%0d at cycle %0d, expected no pulse", $signed(acc1), cyc);
      end else begin
        e = q1.pop_front();
        if ($signed(acc1) !== e.acc || ovf1 !== e.ovf || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL dut1_result: got acc=%0d ovf=%0b cyc=%0d, expected acc=%0d ovf=%0b cyc=%0d",
                   $signed(acc1), ovf1, cyc, e.acc, e.ovf, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic signed [31:0] a2;
    a2 = 32'($signed(acc2));
    if (rst_n && vo2) begin
      n_chk++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL dut2_stray_pulse: got acc=%0d at cycle %0d, expected no pulse", a2, cyc);
      end else begin
        e = q2.pop_front();
        if (a2 !== e.acc || ovf2 !== e.ovf || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL dut2_result: got acc=%0d ovf=%0b cyc=%0d, expected acc=%0d ovf=%0b cyc=%0d",
                   a2, ovf2, cyc, e.acc, e.ovf, e.cyc);
        end
      end
    end
  end

  initial begin
    #1;
    chk("reset_valid_out", vo1, 0);
    chk("reset_acc_out", acc1, 0);
    chk("reset_busy", busy1, 0);
    idle(2);
    @(negedge clk) rst_n = 1'b1;

    // Warm-up frame so the mid-frame reset has non-zero outputs to clear.
    frame(1, 5, 5, 5, 5, 20, 0);
    send(1, 1, 0, 0, 0, 0);
    send(1, 2, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_valid_out", vo1, 0);
    chk("midreset_acc_out", acc1, 0);
    chk("midreset_ovf_out", ovf1, 0);
    chk("midreset_busy", busy1, 0);
    @(negedge clk) rst_n = 1'b1;

    frame(1, 1, 2, 3, 4, 10, 0);
    idle(2);

    // Back-to-back frames with valid held high.
    frame(1, -5, -5, -5, -5, -20, 0);
    frame(1, 7, 7, 7, 7, 28, 0);
    idle(2);

    // Gapped frame; busy spans first sample to the cycle after the last.
    send(1, 100, 0, 0, 0, 0);
    chk("gap_busy_after_first", busy1, 1);
    idle(1);
    chk("gap_busy_in_gap", busy1, 1);
    send(1, 200, 0, 0, 0, 0);
    send(1, 300, 0, 0, 0, 0);
    idle(3);
    send(1, 400, 0, 1, 1000, 0);
    chk("gap_busy_after_last", busy1, 0);
    chk("gap_valid_out", vo1, 1);
    idle(2);

    // Flush with a sample restarts the frame.
    send(1, 2, 0, 0, 0, 0);
    send(1, 3, 0, 0, 0, 0);
    send(1, 9, 1, 0, 0, 0);
    send(1, 1, 0, 0, 0, 0);
    send(1, 1, 0, 0, 0, 0);
    send(1, 1, 0, 1, 12, 0);
    idle(2);

    // Flush on the last-sample cycle: no pulse, the sample opens a new frame.
    send(1, 1, 0, 0, 0, 0);
    send(1, 1, 0, 0, 0, 0);
    send(1, 1, 0, 0, 0, 0);
    send(1, 5, 1, 0, 0, 0);
    chk("flush_last_no_pulse", vo1, 0);
    chk("flush_last_busy", busy1, 1);
    send(1, 6, 0, 0, 0, 0);
    send(1, 7, 0, 0, 0, 0);
    send(1, 8, 0, 1, 26, 0);
    idle(2);

    // Flush without a sample returns to idle.
    send(1, 3, 0, 0, 0, 0);
    send(1, 3, 0, 0, 0, 0);
    @(negedge clk) f1 = 1'b1;
    @(posedge clk) #1 f1 = 1'b0;
    chk("flush_idle_busy", busy1, 0);
    frame(1, 10, 20, 30, 40, 100, 0);
    idle(2);

    // Narrow output (WO=16, SHIFT=2): overflow, floor shift, positive boundary.
    frame(2, 32768, 32768, 32768, 32768, SAT ? 32767 : -32768, 1);
    frame(2, -8, -8, -8, -9, -9, 0);
    frame(2, 32767, 32767, 32767, 32770, 32767, 0);
    idle(2);

    // Full-scale products in the 34-bit accumulator.
    frame(1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
          SAT ? 32'sh8000_0000 : 0, 1);
    frame(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
          SAT ? 32'sh7FFF_FFFF : -4, 1);
    idle(5);

    chk("dut1_queue_drained", q1.size(), 0);
    chk("dut2_queue_drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
